// File: rtl/dog_window_sched_if.sv
// Pixel-source / window-datapath bundle for dog_window_sched.
// master = the scheduler, slave = pixel source plus line-buffer/window/DoGSum datapath.
interface dog_window_sched_if #(
    parameter int COL_W = 9,
    parameter int ROW_W = 8
);
    logic             frame_start;
    logic             pix_valid;
    logic             pix_ready;
    logic             lb_wr_en;
    logic [1:0]       lb_wr_sel;
    logic [COL_W-1:0] lb_addr;
    logic             win_shift;
    logic             win_valid;
    logic             dog_valid;
    logic [ROW_W-1:0] dog_row;
    logic [COL_W-1:0] dog_col;
    logic             busy;
    logic             frame_done;

    modport master (
        input  frame_start, pix_valid,
        output pix_ready, lb_wr_en, lb_wr_sel, lb_addr, win_shift, win_valid,
               dog_valid, dog_row, dog_col, busy, frame_done
    );

    modport slave (
        output frame_start, pix_valid,
        input  pix_ready, lb_wr_en, lb_wr_sel, lb_addr, win_shift, win_valid,
               dog_valid, dog_row, dog_col, busy, frame_done
    );
endinterface

// File: rtl/dog_window_sched.sv
// Raster-to-5x5-window scheduler in front of DoGSum: counts pixels, rotates
// line-buffer banks, qualifies interior windows and tags DoG results with
// their centre coordinates after the DoGSum latency.
module dog_window_sched #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int COL_W   = 9,
    parameter int ROW_W   = 8,
    parameter int DOG_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    dog_window_sched_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int FL_W = $clog2(DOG_LAT + 2) + 1;
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [FL_W-1:0]  FLUSH_END = FL_W'(DOG_LAT + 1);

    state_t           state, stateNxt;
    logic [FL_W-1:0]  flushCnt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             accept, lastPix;

    // Window qualification stage, then the DoGSum-latency delay line.
    // vldPipe[0] is win_valid; vldPipe[DOG_LAT] is dog_valid.
    logic                           qualVld;
    logic [ROW_W-1:0]               qualRow;
    logic [COL_W-1:0]               qualCol;
    logic [DOG_LAT:0]               vldPipe;
    logic [DOG_LAT-1:0][ROW_W-1:0]  rowPipe;
    logic [DOG_LAT-1:0][COL_W-1:0]  colPipe;

    assign accept  = bus.pix_valid & (state == RUN);
    assign lastPix = accept & (row == LAST_ROW) & (col == LAST_COL);

    assign bus.win_valid = vldPipe[0];
    assign bus.dog_valid = vldPipe[DOG_LAT];

    // Next-state and state-decoded outputs.
    always_comb begin
        stateNxt       = state;
        bus.pix_ready  = 1'b0;
        bus.busy       = 1'b0;
        bus.frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_start) stateNxt = RUN;
            end
            RUN: begin
                bus.pix_ready = 1'b1;
                bus.busy      = 1'b1;
                if (lastPix) stateNxt = FLUSH;
            end
            FLUSH: begin
                bus.busy = 1'b1;
                if (flushCnt == FLUSH_END) stateNxt = DONE;
            end
            DONE: begin
                bus.frame_done = 1'b1;
                stateNxt       = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNxt;
    end

    // Flush timer: zero outside FLUSH, so it starts at 0 on entry.
    always_ff @(posedge clk) begin
        if (rst || state != FLUSH) flushCnt <= '0;
        else                       flushCnt <= flushCnt + FL_W'(1);
    end

    // Raster position of the next pixel to accept; cleared at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && bus.frame_start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Line-buffer write and window shift strobes; address/bank hold between accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.lb_wr_en  <= 1'b0;
            bus.win_shift <= 1'b0;
            bus.lb_addr   <= '0;
            bus.lb_wr_sel <= '0;
        end else begin
            bus.lb_wr_en  <= accept;
            bus.win_shift <= accept;
            if (accept) begin
                bus.lb_addr   <= col;
                bus.lb_wr_sel <= row[1:0];
            end
        end
    end

    // Mark pixels that complete a full interior window (c<4 also blocks row-wrap windows).
    always_ff @(posedge clk) begin
        if (rst) begin
            qualVld <= 1'b0;
            qualRow <= '0;
            qualCol <= '0;
        end else begin
            qualVld <= accept & (row >= ROW_W'(4)) & (col >= COL_W'(4));
            qualRow <= row - ROW_W'(2);
            qualCol <= col - COL_W'(2);
        end
    end

    // Delay valid and centre through DoGSum latency; output coordinates hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vldPipe     <= '0;
            rowPipe     <= '0;
            colPipe     <= '0;
            bus.dog_row <= '0;
            bus.dog_col <= '0;
        end else begin
            vldPipe    <= {vldPipe[DOG_LAT-1:0], qualVld};
            rowPipe[0] <= qualRow;
            colPipe[0] <= qualCol;
            for (int i = 1; i < DOG_LAT; i++) begin
                rowPipe[i] <= rowPipe[i-1];
                colPipe[i] <= colPipe[i-1];
            end
            if (vldPipe[DOG_LAT-1]) begin
                bus.dog_row <= rowPipe[DOG_LAT-1];
                bus.dog_col <= colPipe[DOG_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_dog_window_sched.sv
// Self-checking bench for dog_window_sched (8x6 image, DoG latency 3).
// A per-cycle expectation timeline is built from the accept events the bench
// itself causes; frame-level tables check centres, bank rotation and counts.
module tb_dog_window_sched;
    localparam int W = 8, H = 6, L = 3, CW = 3, RW = 3, N = 4096, NPIX = W * H;

    typedef struct { int row; int col; } cen_t;
    typedef struct { int sel; int addr; } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dog_window_sched_if #(.COL_W(CW), .ROW_W(RW)) bus();

    dog_window_sched #(.IMG_W(W), .IMG_H(H), .COL_W(CW), .ROW_W(RW), .DOG_LAT(L)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int nChk = 0, nFail = 0;
    int edgeCnt = 0;
    bit monOn = 0;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Expected timeline, indexed by number of rising edges elapsed.
    bit          eRdy[N], eWr[N], eWin[N], eDog[N], eBusy[N], eDone[N], eRst[N];
    bit [CW-1:0] eAddr[N], eDc[N];
    bit [1:0]    eSel[N];
    bit [RW-1:0] eDr[N];

    // Frame model.
    bit running = 0;
    int pixCnt = 0, idleFrom = 0, doneAt = -1, acc36 = -1;

    // Tables.
    cen_t cenTab[8];
    int   selTab[H];

    // Observation logs.
    cen_t dogQ[$];
    wr_t  wrQ[$];
    int doneCnt, lastDogIdx, firstDogIdx, firstWinIdx, doneIdx;
    bit [CW-1:0] hA, hC;
    bit [1:0]    hS;
    bit [RW-1:0] hR;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearFrom(input int k);
        for (int j = k; j < N; j++) begin
            eRdy[j] = 0; eWr[j] = 0; eWin[j] = 0; eDog[j] = 0; eBusy[j] = 0;
            eDone[j] = 0; eRst[j] = 0; eAddr[j] = 0; eDc[j] = 0; eSel[j] = 0; eDr[j] = 0;
        end
    endtask

    task automatic acceptPix(input int k);
        int r, c;
        r = pixCnt / W;
        c = pixCnt % W;
        eWr[k]   = 1;
        eAddr[k] = CW'(c);
        eSel[k]  = 2'(r % 4);
        if (r >= 4 && c >= 4) begin
            eWin[k+1]   = 1;
            eDog[k+1+L] = 1;
            eDr[k+1+L]  = RW'(r - 2);
            eDc[k+1+L]  = CW'(c - 2);
        end
        if (r == 4 && c == 4) acc36 = k;
        pixCnt++;
        if (pixCnt == NPIX) begin
            running = 0;
            for (int j = k; j <= k + L + 1; j++) eBusy[j] = 1;
            doneAt = k + L + 2;
            eDone[doneAt] = 1;
            idleFrom = doneAt + 2;
        end
    endtask

    // Drive inputs for the next rising edge, update the model, advance one cycle.
    task automatic step(input bit fs, input bit pv, input bit rs);
        int k;
        k = edgeCnt + 1;
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        rst             = rs;
        if (rs) begin
            clearFrom(k);
            eRst[k]  = 1;
            running  = 0;
            idleFrom = k + 1;
        end else if (running) begin
            eBusy[k] = 1;
            if (pv) acceptPix(k);
            if (running) eRdy[k] = 1;
        end else if (fs && k >= idleFrom) begin
            running  = 1;
            pixCnt   = 0;
            eRdy[k]  = 1;
            eBusy[k] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every output against the timeline, plus logging.
    always @(negedge clk) begin
        int i;
        logic [17:0] ev, av;
        cen_t t;
        wr_t  w;
        if (monOn && edgeCnt < N) begin
            i = edgeCnt;
            if (eRst[i]) begin hA = 0; hS = 0; hR = 0; hC = 0; end
            if (eWr[i])  begin hA = eAddr[i]; hS = eSel[i]; end
            if (eDog[i]) begin hR = eDr[i]; hC = eDc[i]; end
            ev = {eRdy[i], eWr[i], eWr[i], hS, hA, eWin[i], eDog[i], hR, hC, eBusy[i], eDone[i]};
            av = {bus.pix_ready, bus.lb_wr_en, bus.win_shift, bus.lb_wr_sel, bus.lb_addr,
                  bus.win_valid, bus.dog_valid, bus.dog_row, bus.dog_col, bus.busy, bus.frame_done};
            chk($sformatf("cycle%0d_outputs", i), 32'(av), 32'(ev));
            if (bus.dog_valid === 1'b1) begin
                t.row = int'(bus.dog_row);
                t.col = int'(bus.dog_col);
                dogQ.push_back(t);
                lastDogIdx = i;
                if (firstDogIdx < 0) firstDogIdx = i;
            end
            if (bus.win_valid === 1'b1 && firstWinIdx < 0) firstWinIdx = i;
            if (bus.lb_wr_en === 1'b1) begin
                w.sel  = int'(bus.lb_wr_sel);
                w.addr = int'(bus.lb_addr);
                wrQ.push_back(w);
            end
            if (bus.frame_done === 1'b1) begin
                doneCnt++;
                doneIdx = i;
            end
        end
    end

    task automatic clearLogs();
        dogQ.delete();
        wrQ.delete();
        doneCnt = 0; lastDogIdx = -1; firstDogIdx = -1; firstWinIdx = -1; doneIdx = -1;
    endtask

    // One frame: start, NPIX accepts with optional gaps and frame_start noise,
    // then drain through FLUSH/DONE with pix_valid high (and frame_start landing in DONE).
    task automatic runFrame(input int gapPct, input bit noise);
        int n;
        bit fs, pv;
        step(1, 0, 0);
        n = 0;
        while (running && n < 2000) begin
            pv = (gapPct == 0) ? 1'b1 : ($urandom_range(99) >= gapPct);
            fs = noise && ($urandom_range(3) == 0);
            step(fs, pv, 0);
            n++;
        end
        n = 0;
        while (edgeCnt < doneAt + 3 && n < 50) begin
            fs = noise && (edgeCnt + 1 == doneAt + 1);
            step(fs, 1, 0);
            n++;
        end
        chk("frame_end_idle", 32'({bus.busy, bus.pix_ready}), 32'(0));
    endtask

    task automatic checkFrame(input string tag);
        chk({tag, "_dog_count"}, 32'(dogQ.size()), 32'(8));
        for (int i = 0; i < 8 && i < dogQ.size(); i++) begin
            chk($sformatf("%s_centre%0d_row", tag, i), 32'(dogQ[i].row), 32'(cenTab[i].row));
            chk($sformatf("%s_centre%0d_col", tag, i), 32'(dogQ[i].col), 32'(cenTab[i].col));
        end
        chk({tag, "_wr_count"}, 32'(wrQ.size()), 32'(NPIX));
        for (int i = 0; i < NPIX && i < wrQ.size(); i++) begin
            chk($sformatf("%s_wr%0d_sel", tag, i), 32'(wrQ[i].sel), 32'(selTab[i / W]));
            chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wrQ[i].addr), 32'(i % W));
        end
        chk({tag, "_done_count"}, 32'(doneCnt), 32'(1));
        chk({tag, "_done_after_last_dog"}, 32'(doneIdx > lastDogIdx), 32'(1));
    endtask

    initial begin
        cenTab[0] = '{2, 2}; cenTab[1] = '{2, 3}; cenTab[2] = '{2, 4}; cenTab[3] = '{2, 5};
        cenTab[4] = '{3, 2}; cenTab[5] = '{3, 3}; cenTab[6] = '{3, 4}; cenTab[7] = '{3, 5};
        selTab[0] = 0; selTab[1] = 1; selTab[2] = 2; selTab[3] = 3; selTab[4] = 0; selTab[5] = 1;

        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        rst             = 1'b1;
        clearLogs();
        monOn = 1;

        // Reset, then pix_valid high while idle.
        step(0, 0, 1);
        step(0, 0, 1);
        chk("reset_state", 32'({bus.busy, bus.pix_ready, bus.frame_done, bus.dog_valid,
                                 bus.lb_wr_en, bus.win_valid}), 32'(0));
        step(0, 1, 0);
        step(0, 1, 0);

        // Full frame with pix_valid held high; first-window latency.
        clearLogs();
        runFrame(0, 0);
        checkFrame("s1");
        chk("s2_first_win_cycle", 32'(firstWinIdx), 32'(acc36 + 1));
        chk("s2_first_dog_cycle", 32'(firstDogIdx), 32'(acc36 + 1 + L));

        // Random stalls, frame_start noise in RUN and a pulse in DONE.
        clearLogs();
        runFrame(50, 1);
        checkFrame("s4");

        // Reset after 20 pixels, then a clean frame.
        clearLogs();
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        step(0, 1, 1);
        chk("s6_rst_outputs", 32'({bus.pix_ready, bus.lb_wr_en, bus.win_shift, bus.lb_wr_sel,
                                    bus.lb_addr, bus.win_valid, bus.dog_valid, bus.dog_row,
                                    bus.dog_col, bus.busy, bus.frame_done}), 32'(0));
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        chk("s6_no_done_after_rst", 32'(doneCnt), 32'(0));
        clearLogs();
        runFrame(0, 0);
        checkFrame("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule

// File: doc/dog_window_sched.md
Name: dog_window_sched

Overview:
Sequences a raster pixel stream into the 5x5 window datapath that feeds DoGSum.
- Counts row and column of each accepted pixel.
- Schedules line-buffer writes through a 4-bank rotation and issues window-shift strobes.
- Qualifies windows whose 5x5 neighbourhood lies entirely inside the image.
- Tracks DoGSum latency so each DoG result leaves with a valid strobe and centre coordinates.
- Sits between the pixel source and the line-buffer/window-register/DoGSum datapath. Owns frame start/end handshakes.

Parameters:
IMG_W, 320, image width in pixels (>=5)
IMG_H, 240, image height in pixels (>=5)
COL_W, 9, column counter width (2^COL_W >= IMG_W)
ROW_W, 8, row counter width (2^ROW_W >= IMG_H)
DOG_LAT, 3, DoGSum pipeline latency in clocks (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle request to begin a frame
pix_valid  in  1  source has a pixel this cycle
pix_ready  out  1  scheduler accepts a pixel (accept = pix_valid & pix_ready)
lb_wr_en  out  1  write the accepted pixel into line buffer lb_wr_sel
lb_wr_sel  out  2  line-buffer bank to write (row mod 4)
lb_addr  out  COL_W  line-buffer read/write address (column)
win_shift  out  1  shift the 5x5 window register one column
win_valid  out  1  window at DoGSum inputs is a full interior window
dog_valid  out  1  DoG output of DoGSum is valid this cycle
dog_row  out  ROW_W  centre row of the window producing DoG
dog_col  out  COL_W  centre column of the window producing DoG
busy  out  1  high in RUN and FLUSH
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: every output is 0, the state is IDLE, all counters and delay pipes are 0. Reset mid-frame abandons the frame; no frame_done is issued.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - pix_ready=0.
  - frame_start=1 -> RUN, with row=0, col=0.
- RUN:
  - pix_ready=1. frame_start is ignored.
  - On each accept:
    - col increments. At col==IMG_W-1, col wraps to 0 and row increments.
    - Accepting pixel (IMG_H-1, IMG_W-1) -> FLUSH.
  - pix_valid=0 stalls the counters, and the strobe outputs are 0 that cycle.
- Strobe timing: outputs are registered. For an accept at edge k, the following hold in cycle k+1:
  - lb_wr_en=1 and win_shift=1.
  - lb_addr = col of the accepted pixel.
  - lb_wr_sel = row mod 4.
  - In all other cycles lb_wr_en=0 and win_shift=0. lb_addr and lb_wr_sel hold their last values.
- Window qualification:
  - An accepted pixel at (r,c) with r>=4 and c>=4 produces win_valid=1 in cycle k+2, after the window register shifts at edge k+1.
  - Its centre is (r-2, c-2).
  - Columns c<4 never produce win_valid; this covers row wrap, so no window straddles two rows.
- Latency tracking:
  - win_valid and the centre coordinates pass through a DOG_LAT-stage delay line.
  - dog_valid is asserted in cycle k+2+DOG_LAT, and dog_row/dog_col are valid with it.
  - When dog_valid=0, dog_row and dog_col hold their previous values.
- FLUSH:
  - pix_ready=0. A cycle counter starts at 0 on entry.
  - When the counter reaches DOG_LAT+1 -> DONE. This guarantees the last dog_valid is issued before frame_done.
- DONE: frame_done=1 for exactly one cycle, then IDLE. frame_start in DONE is ignored.
- Results per frame: (IMG_W-4)*(IMG_H-4) dog_valid pulses, in raster order of the centre.
- busy = (state==RUN) | (state==FLUSH).

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, DOG_LAT=3.
1. Reset, then frame_start, then 48 pixels with pix_valid held high -> exactly 8 dog_valid pulses. Centres in order: (2,2),(2,3),(2,4),(2,5),(3,2),(3,3),(3,4),(3,5). frame_done pulses once, after the last dog_valid.
2. First interior window: the 37th accepted pixel (4,4) at edge k -> win_valid in cycle k+2, dog_valid in cycle k+5 with dog_row=2, dog_col=2. No dog_valid appears before it.
3. Line-buffer rotation: across the frame, lb_wr_sel is 0,1,2,3,0,1 for rows 0..5. lb_addr runs 0..7 each row. lb_wr_en count equals 48.
4. Random pix_valid gaps (about 50% duty) -> the same 8 centres in the same order. No strobes occur in stall cycles, and the counters never advance without an accept.
5. frame_start pulsed mid-RUN and in DONE -> no effect. pix_valid high in IDLE/FLUSH -> pix_ready=0 and no counter change.
6. rst asserted after 20 pixels -> in the next cycle all outputs are 0 and the state is IDLE, with no frame_done. A following full frame reproduces scenario 1 exactly.
